// File: rtl/mole_scheduler_pkg.sv
// Shared types and constants for the mole scheduler: state encoding,
// difficulty codes and the LFSR feedback polynomial.
package mole_scheduler_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_GAP  = 2'd1,
    S_SHOW = 2'd2,
    S_COOL = 2'd3
  } state_e;

  localparam logic [1:0] DIFF_EASY = 2'b00;
  localparam logic [1:0] DIFF_MED  = 2'b01;
  localparam logic [1:0] DIFF_HARD = 2'b10;

  // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    lfsr_step = v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
  endfunction

endpackage

// File: rtl/mole_scheduler_lfsr16.sv
// 16-bit Galois LFSR, free-running every cycle outside reset. A zero seed
// would lock the register at zero, so it is replaced by 1.
module lfsr16
  import mole_scheduler_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic [15:0] q_q, q_d, seed_eff;

  // Next value and effective seed
  always_comb begin
    seed_eff = (seed == 16'h0000) ? 16'h0001 : seed;
    q_d      = lfsr_step(q_q);
  end

  // Shift register; reload seed on reset
  always_ff @(posedge clk) begin
    if (rst) q_q <= seed_eff;
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/mole_scheduler.sv
// Mole field sequencer: dark gap, lit window, cooldown after a hit. Judges
// rising edges of the mole buttons against the lit mole and emits one-cycle
// hit / timeout / miss pulses.
module mole_scheduler
  import mole_scheduler_pkg::*;
#(
  parameter int          N_MOLES     = 8,
  parameter int          CLKS_PER_MS = 50000,
  parameter int          SHOW_MS_E   = 1500,
  parameter int          SHOW_MS_M   = 1000,
  parameter int          SHOW_MS_H   = 600,
  parameter int          GAP_MS      = 300,
  parameter int          COOL_MS     = 200,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic [1:0]                 difficulty,
  input  logic [N_MOLES-1:0]         btn_mole,
  output logic [N_MOLES-1:0]         mole_led,
  output logic [$clog2(N_MOLES)-1:0] active_idx,
  output logic                       hit_pulse,
  output logic                       timeout_pulse,
  output logic                       miss_pulse,
  output logic                       busy
);

  localparam int IW = $clog2(N_MOLES);
  localparam int PW = $clog2(CLKS_PER_MS + 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(CLKS_PER_MS - 1);

  state_e             state_q, state_d;
  logic [PW-1:0]      pre_q, pre_d;
  logic [15:0]        ms_q, ms_d;
  logic [15:0]        show_ms_q, show_ms_d;
  logic [N_MOLES-1:0] led_q, led_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [N_MOLES-1:0] btn_q, btn_d;
  logic               hit_q, hit_d;
  logic               to_q, to_d;
  logic               miss_q, miss_d;

  logic [15:0]        lfsr;
  logic [N_MOLES-1:0] rise;
  logic [15:0]        dur_ms, show_sel;
  logic [IW-1:0]      cand;
  logic               tick, last;
  logic               unused_lfsr_hi;

  lfsr16 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .seed (LFSR_SEED),
    .q    (lfsr)
  );

  // Only the low bits pick the mole; the rest just feed the sequence
  assign unused_lfsr_hi = ^lfsr[15:IW];

  // Window length for the next mole, sampled at SHOW entry
  always_comb begin
    case (difficulty)
      DIFF_EASY: show_sel = 16'(SHOW_MS_E);
      DIFF_MED:  show_sel = 16'(SHOW_MS_M);
      DIFF_HARD: show_sel = 16'(SHOW_MS_H);
      default:   show_sel = 16'(SHOW_MS_H);
    endcase
  end

  // Next-state, hit judge and timer control
  always_comb begin
    rise = btn_mole & ~btn_q;
    tick = (pre_q == PRE_LAST);

    case (state_q)
      S_GAP:   dur_ms = 16'(GAP_MS);
      S_SHOW:  dur_ms = show_ms_q;
      S_COOL:  dur_ms = 16'(COOL_MS);
      default: dur_ms = 16'd1;
    endcase
    last = tick && (ms_q == dur_ms - 16'd1);

    // Never light the same mole twice in a row
    cand = lfsr[IW-1:0];
    if (cand == idx_q) cand = cand + IW'(1);

    state_d   = state_q;
    led_d     = led_q;
    idx_d     = idx_q;
    show_ms_d = show_ms_q;
    btn_d     = btn_mole;
    hit_d     = 1'b0;
    to_d      = 1'b0;
    miss_d    = 1'b0;

    if (!enable) begin
      state_d = S_IDLE;
      led_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_GAP;
        S_GAP: begin
          if (last) begin
            state_d   = S_SHOW;
            idx_d     = cand;
            led_d     = N_MOLES'(1) << cand;
            show_ms_d = show_sel;
          end
        end
        S_SHOW: begin
          // Correct press beats both expiry and a simultaneous wrong press
          if (rise[idx_q]) begin
            hit_d   = 1'b1;
            led_d   = '0;
            state_d = S_COOL;
          end else if (last) begin
            to_d    = 1'b1;
            led_d   = '0;
            state_d = S_GAP;
          end else if (|rise) begin
            miss_d = 1'b1;
          end
        end
        S_COOL:  if (last) state_d = S_GAP;
        default: state_d = S_IDLE;
      endcase
    end

    // Every state starts with a fresh timer so it lasts exactly its length
    if (state_d != state_q || state_d == S_IDLE) begin
      pre_d = '0;
      ms_d  = '0;
    end else if (tick) begin
      pre_d = '0;
      ms_d  = ms_q + 16'd1;
    end else begin
      pre_d = pre_q + PW'(1);
      ms_d  = ms_q;
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pre_q     <= '0;
      ms_q      <= '0;
      show_ms_q <= '0;
      led_q     <= '0;
      idx_q     <= '0;
      btn_q     <= '0;
      hit_q     <= 1'b0;
      to_q      <= 1'b0;
      miss_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_q     <= pre_d;
      ms_q      <= ms_d;
      show_ms_q <= show_ms_d;
      led_q     <= led_d;
      idx_q     <= idx_d;
      btn_q     <= btn_d;
      hit_q     <= hit_d;
      to_q      <= to_d;
      miss_q    <= miss_d;
    end
  end

  assign mole_led      = led_q;
  assign active_idx    = idx_q;
  assign hit_pulse     = hit_q;
  assign timeout_pulse = to_q;
  assign miss_pulse    = miss_q;
  assign busy          = (state_q != S_IDLE);

endmodule
